// File: rtl/rom_serial_bank_pkg.sv
// rom_serial_bank_pkg: word timing constants, timing decode bundle and ROM image shared by the serial ROM bank.
package rom_serial_bank_pkg;
    localparam int ROM_ADDR_W = 8;
    localparam int ROM_INST_W = 10;
    localparam logic [5:0] T_IA_FIRST  = 6'd20;
    localparam logic [5:0] T_IA_LAST   = 6'd27;
    localparam logic [5:0] T_FETCH     = 6'd28;
    localparam logic [5:0] T_IS_FIRST  = 6'd45;
    localparam logic [5:0] T_IS_LAST   = 6'd54;
    localparam logic [5:0] T_WORD_LAST = 6'd55;
    localparam logic [6:0] ROMSEL_OP   = 7'b1000000;

    typedef struct packed {
        logic locked;
        logic ia_win;
        logic fetch;
        logic is_win;
        logic decode;
    } word_timing_t;

    // Fixed ROM contents per bank; address 0x3A holds the reference instruction in every bank.
    function automatic logic [9:0] rom_image(input logic [2:0] id, input logic [7:0] a);
        return (a == 8'h3A) ? 10'h2C5 : ({a, 2'b00} ^ {id, 7'h15} ^ {2'b00, a});
    endfunction
endpackage

// File: rtl/rom_word_timer.sv
// rom_word_timer: 56-slot word counter aligned by sync rising edges, window decodes and lock state.
// Optional sticky sync framing checker when ROM_SYNC_CHECK_EN is defined.
module rom_word_timer
    import rom_serial_bank_pkg::*;
(
    input  logic         cph2,
    input  logic         pon,
    input  logic         sync,
    output word_timing_t tim,
    output logic         sync_err
);
    logic [5:0] t_cnt_q, t_cnt_d;
    logic       locked_q, locked_d;
    logic       sync_q;
    logic       sync_rise;

    always_comb begin
        sync_rise  = sync & ~sync_q;
        t_cnt_d    = sync_rise ? T_IS_FIRST + 6'd1 : (t_cnt_q == T_WORD_LAST) ? 6'd0 : t_cnt_q + 6'd1;
        locked_d   = locked_q | sync_rise;
        tim.locked = locked_q;
        tim.ia_win = (t_cnt_q >= T_IA_FIRST) && (t_cnt_q <= T_IA_LAST);
        tim.fetch  = t_cnt_q == T_FETCH;
        tim.is_win = (t_cnt_q >= T_IS_FIRST) && (t_cnt_q <= T_IS_LAST);
        // a realigning sync edge wins over the select decode
        tim.decode = (t_cnt_q == T_WORD_LAST) && !sync_rise;
    end

    always_ff @(posedge cph2 or posedge pon) begin
        if (pon) begin
            t_cnt_q  <= 6'd0;
            locked_q <= 1'b0;
            sync_q   <= 1'b0;
        end else begin
            t_cnt_q  <= t_cnt_d;
            locked_q <= locked_d;
            sync_q   <= sync;
        end
    end

`ifdef ROM_SYNC_CHECK_EN
    logic [3:0] run_q, run_d;
    logic       err_q, err_d;

    always_comb begin
        run_d = sync ? ((run_q == 4'hF) ? run_q : run_q + 4'd1) : 4'd0;
        err_d = err_q | (~sync & sync_q & (run_q != 4'd10)) | (sync_rise & locked_q & (t_cnt_q != T_IS_FIRST));
    end

    always_ff @(posedge cph2 or posedge pon) begin
        if (pon) begin
            run_q <= 4'd0;
            err_q <= 1'b0;
        end else begin
            run_q <= run_d;
            err_q <= err_d;
        end
    end

    assign sync_err = err_q;
`else
    assign sync_err = 1'b0;
`endif
endmodule

// File: rtl/rom_serial_bank.sv
// rom_serial_bank: serial ROM bank taking an address on IA and shifting the instruction onto IS when selected.
// ROM_SYNC_CHECK_EN enables the sticky sync framing error flag in rom_word_timer.
module rom_serial_bank
    import rom_serial_bank_pkg::*;
#(
    parameter int ROM_ID = 0,
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int INST_W = ROM_INST_W
) (
    input  logic cph2,
    input  logic pon,
    input  logic ia,
    input  logic sync,
    input  logic is_in,
    output logic is_out,
    output logic is_oe,
    output logic bank_act,
    output logic sync_err
);
    word_timing_t      tim;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INST_W-1:0] out_q, out_d;
    logic [INST_W-1:0] mon_q, mon_d;
    logic              act_q, act_d;
    logic [INST_W-1:0] mem [2**ADDR_W];

    for (genvar a = 0; a < 2**ADDR_W; a++) begin : g_rom
        assign mem[a] = INST_W'(rom_image(3'(ROM_ID), 8'(a)));
    end

    rom_word_timer u_timer (
        .cph2     (cph2),
        .pon      (pon),
        .sync     (sync),
        .tim      (tim),
        .sync_err (sync_err)
    );

    always_comb begin
        addr_d = tim.ia_win ? {ia, addr_q[ADDR_W-1:1]} : addr_q;
        out_d  = (tim.fetch && tim.locked) ? mem[addr_q] : (tim.is_win && tim.locked) ? out_q >> 1 : out_q;
        mon_d  = tim.is_win ? {is_in, mon_q[INST_W-1:1]} : mon_q;
        // selection changes only at word end, so the fetched word is still emitted by the old bank
        act_d  = (tim.decode && mon_q[6:0] == ROMSEL_OP) ? (mon_q[INST_W-1 -: 3] == 3'(ROM_ID)) : act_q;
        is_oe  = tim.is_win & tim.locked & act_q;
        is_out = is_oe & out_q[0];
    end

    always_ff @(posedge cph2 or posedge pon) begin
        if (pon) begin
            addr_q <= '0;
            out_q  <= '0;
            mon_q  <= '0;
            act_q  <= (ROM_ID == 0);
        end else begin
            addr_q <= addr_d;
            out_q  <= out_d;
            mon_q  <= mon_d;
            act_q  <= act_d;
        end
    end

    assign bank_act = act_q;
endmodule
